// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// scoreboard entry layout.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned SEL_BITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_BR = 2'd1,
        ST_FLUSH   = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic                    v;
        logic [SEL_BITS_DEF-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// In-flight register-write tracker: one entry per cycle until write-back.
// HAZARD_WB_BYPASS_EN drops the oldest entry from matching (write-before-read RF).
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned SEL_BITS = SEL_BITS_DEF,
    parameter int unsigned WB_DEPTH = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load_v,
    input  logic [SEL_BITS-1:0] i_load_reg,
    input  logic                i_valid,
    input  logic [SEL_BITS-1:0] i_rsel1,
    input  logic [SEL_BITS-1:0] i_rsel2,
    input  logic                i_use1,
    input  logic                i_use2,
    output logic                o_raw
);

`ifdef HAZARD_WB_BYPASS_EN
    localparam int unsigned CHECK_N = WB_DEPTH - 1;
`else
    localparam int unsigned CHECK_N = WB_DEPTH;
`endif

    sb_entry_t r_sb [WB_DEPTH];
    logic      w_m1;
    logic      w_m2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            r_sb[0] <= '{v: i_load_v, rd: SEL_BITS_DEF'(i_load_reg)};
            for (int unsigned i = 1; i < WB_DEPTH; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

    always_comb begin
        w_m1 = 1'b0;
        w_m2 = 1'b0;
        for (int unsigned i = 0; i < CHECK_N; i++) begin
            if (r_sb[i].v && (r_sb[i].rd == SEL_BITS_DEF'(i_rsel1))) w_m1 = 1'b1;
            if (r_sb[i].v && (r_sb[i].rd == SEL_BITS_DEF'(i_rsel2))) w_m2 = 1'b1;
        end
    end

    assign o_raw = i_valid & ((i_use1 & w_m1) | (i_use2 & w_m2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/control-flow sequencer: RAW stalls, branch wait and wrong-path flush.
// Optional HAZARD_WB_BYPASS_EN shortens RAW stalls by one (see hazard_scoreboard).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned SEL_BITS   = SEL_BITS_DEF,
    parameter int unsigned WB_DEPTH   = 3,
    parameter int unsigned BR_RESOLVE = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [SEL_BITS-1:0] dec_rsel1,
    input  logic [SEL_BITS-1:0] dec_rsel2,
    input  logic                dec_use1,
    input  logic                dec_use2,
    input  logic                dec_wr_en,
    input  logic [SEL_BITS-1:0] dec_wr_reg,
    input  logic                dec_is_branch,
    input  logic                mem_pc_wr,
    output logic                hold_fd,
    output logic                bubble_de,
    output logic                flush_fd,
    output logic [1:0]          state,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic                proto_err
);

    localparam int unsigned BR_W = (BR_RESOLVE < 2) ? 1 : $clog2(BR_RESOLVE + 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [BR_W-1:0]  r_br_cnt;
    logic [BR_W-1:0]  w_br_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_proto_err;
    logic             w_raw;
    logic             w_issue;

    assign w_issue = dec_valid & ~hold_fd;

    hazard_scoreboard #(
        .SEL_BITS (SEL_BITS),
        .WB_DEPTH (WB_DEPTH)
    ) u_scoreboard (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load_v   (w_issue & dec_wr_en),
        .i_load_reg (dec_wr_reg),
        .i_valid    (dec_valid),
        .i_rsel1    (dec_rsel1),
        .i_rsel2    (dec_rsel2),
        .i_use1     (dec_use1),
        .i_use2     (dec_use2),
        .o_raw      (w_raw)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_br_cnt_nxt = r_br_cnt;
        hold_fd      = 1'b0;
        bubble_de    = 1'b0;
        flush_fd     = 1'b0;
        case (r_state)
            ST_RUN: begin
                // RAW wins: a branch waits in decode until its operands clear
                if (w_raw) begin
                    hold_fd   = 1'b1;
                    bubble_de = 1'b1;
                end else if (dec_valid && dec_is_branch) begin
                    w_br_cnt_nxt = BR_W'(BR_RESOLVE);
                    w_state_nxt  = ST_WAIT_BR;
                end
            end
            ST_WAIT_BR: begin
                hold_fd      = 1'b1;
                bubble_de    = 1'b1;
                w_br_cnt_nxt = r_br_cnt - BR_W'(1);
                if (r_br_cnt <= BR_W'(1)) begin
                    w_state_nxt = mem_pc_wr ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_fd    = 1'b1;
                bubble_de   = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_br_cnt    <= '0;
            r_stall_cnt <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_br_cnt <= w_br_cnt_nxt;
            if (hold_fd && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (mem_pc_wr && (r_state != ST_WAIT_BR)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign proto_err = r_proto_err;

endmodule
